// File: rtl/ff_reg_arbiter.sv
// Shared WIDTH-bit register bank updated by NREQ requesters through a round-robin
// arbiter; each granted request applies one LOAD/SET/CLR/TOG operation under a data mask.
module ff_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic                  done,
  output logic [IDW-1:0]        done_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       cap_op_q, cap_op_d;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;
  logic [IDW-1:0]   cap_id_q, cap_id_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       opc,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] res;
    case (opc)
      OP_LOAD: res = d;
      OP_SET:  res = cur | d;
      OP_CLR:  res = cur & ~d;
      OP_TOG:  res = cur ^ d;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Round-robin search: first requester after the last winner, wrapping modulo NREQ.
  always_comb begin : arb_search
    int             sum;
    logic [IDW-1:0] cand;
    sum       = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end else begin
        sum = sum;
      end
      cand = IDW'(sum);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end else begin
        win_found = win_found;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    done_id_d  = done_id_q;
    q_d        = q_q;
    cap_op_d   = cap_op_q;
    cap_data_d = cap_data_q;
    cap_id_d   = cap_id_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          cap_id_d       = win_idx;
          cap_op_d       = op[2*win_idx +: 2];
          cap_data_d     = wdata[WIDTH*win_idx +: WIDTH];
          state_d        = S_EXEC;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        q_d       = apply_op(q_q, cap_op_q, cap_data_q);
        done_d    = 1'b1;
        done_id_d = cap_id_q;
        gnt_d     = '0;
        ptr_d     = cap_id_q;
        state_d   = S_WAIT;
      end
      // Dead cycle lets the served requester drop req before the next arbitration.
      S_WAIT: begin
        done_d  = 1'b0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_RESET;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      q_q        <= '0;
      cap_op_q   <= 2'b00;
      cap_data_q <= '0;
      cap_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      q_q        <= q_d;
      cap_op_q   <= cap_op_d;
      cap_data_q <= cap_data_d;
      cap_id_q   <= cap_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign q       = q_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: doc/ff_reg_arbiter.md
Name: ff_reg_arbiter

Overview:
Shared WIDTH-bit flip-flop register bank whose update is shared between NREQ requesters.
Each requester asks for one update operation with D, JK-set, JK-clear or T semantics applied bitwise under a data mask.
A round-robin arbiter with a three-state controller serialises the requests, and the register is the only storage the requesters can change.
The block sits between control agents and any logic that reads q.

Parameters:
NREQ, 4, number of requesters (minimum 2); IDW = $clog2(NREQ) is derived and is not overridable
WIDTH, 8, register width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level; bit i belongs to requester i
op  input  2*NREQ  per-requester opcode; op[2i+1:2i] belongs to requester i
wdata  input  WIDTH*NREQ  per-requester data/mask; wdata[WIDTH*i +: WIDTH] belongs to requester i
gnt  output  NREQ  one-hot grant, registered
busy  output  1  high whenever the controller is not in IDLE
q  output  WIDTH  register bank contents
done  output  1  one-cycle pulse indicating the granted operation has been applied
done_id  output  IDW  index of the requester whose operation completed; valid while done is high

Behaviour:
- Reset is synchronous, active-high, and all values below apply after the first clk edge with rst=1:
  - q = 0, gnt = 0, done = 0, done_id = 0, busy = 0
  - state = IDLE
  - round-robin pointer ptr = NREQ-1, so requester 0 has the highest priority first
- Opcodes, applied to q with d = winner's wdata:
  - 00 LOAD: q <= d
  - 01 SET: q <= q | d
  - 10 CLR: q <= q & ~d
  - 11 TOG: q <= q ^ d
- IDLE:
  - If req != 0, the winner is the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - On that edge: gnt <= onehot(winner); the winner's op and wdata are captured into internal registers; state <= EXEC.
  - If req == 0: stay in IDLE; q holds.
- EXEC (one cycle):
  - q <= f(q, captured op, captured d); done <= 1; done_id <= winner; gnt <= 0; ptr <= winner; state <= WAIT.
- WAIT (one cycle):
  - done <= 0; state <= IDLE. No sampling of req occurs here.
- Handshake rules:
  - A requester holds req, op and wdata stable from assertion until it sees done with done_id equal to its index.
  - It deasserts req on the next edge.
  - Because of the WAIT cycle, the dropped req is never re-served.
- Timing:
  - Latency: req sampled at edge E0; gnt visible after E0; q updated and done high after E1; done low after E2; the next arbitration happens at E3.
  - Throughput is one operation per 3 cycles.
- Changes to req, op or wdata after the capture edge E0 do not affect the operation in flight, because op and wdata are captured.
- A requester dropping req while its grant is pending is still served and still receives done (no abort).
- Simultaneous requests are served in round-robin order. With all NREQ requesting continuously, each requester is served once per NREQ operations. The pointer wraps from NREQ-1 to 0.
- A single continuously asserted req is re-served every 3 cycles.
- busy = (state != IDLE), registered or decoded from the registered state with no combinational path from req.
- Reset asserted in EXEC or WAIT:
  - The operation is aborted and q is forced to 0.
  - No done is emitted after the reset edge.
  - The pointer returns to NREQ-1.
- gnt is never multi-hot. gnt and done are never high in the same cycle.

Test Plan:
1. Reset with random req/op/wdata applied -> q=00, gnt=0, done=0, busy=0. Release rst, req=0001, op0=00, wdata0=A5 -> gnt=0001 after 1 edge; q=A5, done=1, done_id=0 after 2 edges; done=0 after 3 edges.
2. Starting from q=A5: requester 1 issues SET 0F -> q=AF. Then CLR F0 -> q=0F. Then TOG FF -> q=F0. Each operation completes exactly 3 cycles after the previous req was seen.
3. req=1111 held, each requester holding its own LOAD value (11, 22, 33, 44) -> done_id sequence 0, 1, 2, 3, 0. q follows 11, 22, 33, 44, 11. gnt is always one-hot.
4. Fairness and wrap-around: requester 3 is served, then req=1001 -> requester 0 is next (pointer wraps), then requester 3.
5. Grant pending, requester 2 changes wdata from 3C to FF right after gnt rises -> q gets the captured value 3C. Requester 2 drops req after done -> no second grant.
6. rst pulsed for one cycle while in EXEC, with LOAD 77 pending -> q=00, no done pulse, busy=0. With req=0110 afterwards, requester 1 is granted first.
